// File: rtl/user_module_project_id.sv
// Seven-state, five-symbol Turing-machine transition lookup with a sticky halt flag.
// io_out[7:1] is a pure combinational lookup of {state_in, sym_in}. The lookup
// ignores the clock and reset. io_out[0] is the only register in the block: it
// records that the machine has reached, or is about to reach, the halt state H.
module user_module_project_id (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [2:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4,
    ST_F = 3'd5,
    ST_G = 3'd6,
    ST_H = 3'd7
  } tm_state_e;

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S4 = 3'b100;
  localparam logic [2:0] S5 = 3'b101;

  localparam logic MV_R = 1'b1;
  localparam logic MV_L = 1'b0;

  logic        clk_sys;
  logic        rst_n;
  logic [2:0]  sym_i;
  tm_state_e   state_i;

  logic [2:0]  new_sym;
  logic        dir;
  tm_state_e   next_state;

  logic        halted_q;
  logic        halted_d;

  assign clk_sys = io_in[0];
  assign rst_n   = io_in[1];
  assign sym_i   = io_in[4:2];
  assign state_i = tm_state_e'(io_in[7:5]);

  // Transition lookup. The defaults cover the halt state H and the unused
  // symbol codes: the symbol is echoed back, the head moves left, and the
  // next state is H.
  always_comb begin
    new_sym    = sym_i;
    dir        = MV_L;
    next_state = ST_H;
    case (state_i)
      ST_A: begin
        case (sym_i)
          S0: begin new_sym = S1; dir = MV_R; next_state = ST_B; end
          S1: begin new_sym = S0; dir = MV_L; next_state = ST_A; end
          S2: begin new_sym = S2; dir = MV_R; next_state = ST_A; end
          S4: begin new_sym = S5; dir = MV_R; next_state = ST_C; end
          S5: begin new_sym = S4; dir = MV_L; next_state = ST_D; end
          default: ;
        endcase
      end
      ST_B: begin
        case (sym_i)
          S0: begin new_sym = S2; dir = MV_L; next_state = ST_C; end
          S1: begin new_sym = S1; dir = MV_R; next_state = ST_B; end
          S2: begin new_sym = S0; dir = MV_R; next_state = ST_E; end
          S4: begin new_sym = S4; dir = MV_R; next_state = ST_B; end
          S5: begin new_sym = S1; dir = MV_L; next_state = ST_A; end
          default: ;
        endcase
      end
      ST_C: begin
        case (sym_i)
          S0: begin new_sym = S0; dir = MV_L; next_state = ST_D; end
          S1: begin new_sym = S2; dir = MV_L; next_state = ST_C; end
          S2: begin new_sym = S1; dir = MV_R; next_state = ST_A; end
          S4: begin new_sym = S0; dir = MV_R; next_state = ST_F; end
          S5: begin new_sym = S5; dir = MV_L; next_state = ST_C; end
          default: ;
        endcase
      end
      ST_D: begin
        case (sym_i)
          S0: begin new_sym = S4; dir = MV_R; next_state = ST_E; end
          S1: begin new_sym = S1; dir = MV_L; next_state = ST_D; end
          S2: begin new_sym = S2; dir = MV_L; next_state = ST_B; end
          S4: begin new_sym = S1; dir = MV_R; next_state = ST_G; end
          S5: begin new_sym = S0; dir = MV_R; next_state = ST_A; end
          default: ;
        endcase
      end
      ST_E: begin
        case (sym_i)
          S0: begin new_sym = S5; dir = MV_L; next_state = ST_F; end
          S1: begin new_sym = S4; dir = MV_R; next_state = ST_E; end
          S2: begin new_sym = S2; dir = MV_R; next_state = ST_C; end
          S4: begin new_sym = S0; dir = MV_L; next_state = ST_E; end
          S5: begin new_sym = S1; dir = MV_R; next_state = ST_B; end
          default: ;
        endcase
      end
      ST_F: begin
        case (sym_i)
          S0: begin new_sym = S0; dir = MV_R; next_state = ST_G; end
          S1: begin new_sym = S1; dir = MV_R; next_state = ST_A; end
          S2: begin new_sym = S4; dir = MV_L; next_state = ST_F; end
          S4: begin new_sym = S2; dir = MV_L; next_state = ST_D; end
          S5: begin new_sym = S5; dir = MV_R; next_state = ST_E; end
          default: ;
        endcase
      end
      ST_G: begin
        case (sym_i)
          S0: begin new_sym = S0; dir = MV_L; next_state = ST_H; end
          S1: begin new_sym = S2; dir = MV_R; next_state = ST_G; end
          S2: begin new_sym = S5; dir = MV_L; next_state = ST_A; end
          S4: begin new_sym = S4; dir = MV_R; next_state = ST_C; end
          S5: begin new_sym = S1; dir = MV_L; next_state = ST_F; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Halt detection: either the current or the upcoming state is H. Once set,
  // the flag stays set until the next reset.
  always_comb begin
    halted_d = halted_q | (state_i == ST_H) | (next_state == ST_H);
  end

  // Sticky halt register with asynchronous clear.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign io_out = {next_state, new_sym, dir, halted_q};

endmodule

// File: tb/tb_user_module_project_id.sv
// Scoreboard bench for the Turing-machine lookup and the sticky halt flag.
// The stimulus process pushes hand-computed expected io_out values into a
// queue. A separate monitor process pops each entry and compares it against
// the DUT when the check strobe fires.
module tb_user_module_project_id;

  logic       clk;
  logic       rst_n;
  logic [2:0] sym;
  logic [2:0] st;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {st, sym, rst_n, clk};

  user_module_project_id dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string      sb_name[$];
  logic [7:0] sb_exp[$];
  event       chk_ev;
  int         n_cmp;
  int         n_bad;

  // Expected {next_state, new_sym, dir}. Rows are states A..G. Columns are
  // the symbols S0, S1, S2, S4, S5, in that order.
  logic [6:0] golden [0:6][0:4];
  logic [2:0] sym_codes [0:4];
  logic [2:0] unused_codes [0:2];

  initial begin
    sym_codes[0] = 3'b000; sym_codes[1] = 3'b001; sym_codes[2] = 3'b010;
    sym_codes[3] = 3'b100; sym_codes[4] = 3'b101;
    unused_codes[0] = 3'b011; unused_codes[1] = 3'b110; unused_codes[2] = 3'b111;
    // A
    golden[0][0] = 7'b001_001_1; golden[0][1] = 7'b000_000_0; golden[0][2] = 7'b000_010_1;
    golden[0][3] = 7'b010_101_1; golden[0][4] = 7'b011_100_0;
    // B
    golden[1][0] = 7'b010_010_0; golden[1][1] = 7'b001_001_1; golden[1][2] = 7'b100_000_1;
    golden[1][3] = 7'b001_100_1; golden[1][4] = 7'b000_001_0;
    // C
    golden[2][0] = 7'b011_000_0; golden[2][1] = 7'b010_010_0; golden[2][2] = 7'b000_001_1;
    golden[2][3] = 7'b101_000_1; golden[2][4] = 7'b010_101_0;
    // D
    golden[3][0] = 7'b100_100_1; golden[3][1] = 7'b011_001_0; golden[3][2] = 7'b001_010_0;
    golden[3][3] = 7'b110_001_1; golden[3][4] = 7'b000_000_1;
    // E
    golden[4][0] = 7'b101_101_0; golden[4][1] = 7'b100_100_1; golden[4][2] = 7'b010_010_1;
    golden[4][3] = 7'b100_000_0; golden[4][4] = 7'b001_001_1;
    // F
    golden[5][0] = 7'b110_000_1; golden[5][1] = 7'b000_001_1; golden[5][2] = 7'b101_100_0;
    golden[5][3] = 7'b011_010_0; golden[5][4] = 7'b100_101_1;
    // G
    golden[6][0] = 7'b111_000_0; golden[6][1] = 7'b110_010_1; golden[6][2] = 7'b000_101_0;
    golden[6][3] = 7'b010_100_1; golden[6][4] = 7'b101_001_0;
  end

  // Monitor: sample 1 time unit after each strobe and compare against the oldest expectation.
  initial begin
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(chk_ev);
      #1;
      n_cmp++;
      if (sb_exp.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: io_out=%b with no expectation queued", io_out);
      end else begin
        string      nm;
        logic [7:0] e;
        nm = sb_name.pop_front();
        e  = sb_exp.pop_front();
        if (io_out !== e) begin
          n_bad++;
          $display("FAIL %s: io_out got %b expected %b", nm, io_out, e);
        end
      end
    end
  end

  // Queue one expectation and strobe the monitor after inputs have settled.
  task automatic chk(input string nm, input logic [7:0] e);
    #1;
    sb_name.push_back(nm);
    sb_exp.push_back(e);
    -> chk_ev;
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    st    = 3'd0;
    sym   = 3'd0;
    #12;

    // Reset state: A / S0 gives next B, symbol 001, move right; halted is 0.
    @(negedge clk);
    chk("reset_A_S0", 8'b0010011_0);

    // Full table while reset is held: the lookup stays live and halted stays 0.
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        st  = 3'(s);
        sym = sym_codes[k];
        if (s == 7)
          chk($sformatf("lut_H_sym%0d", k), {3'b111, sym_codes[k], 1'b0, 1'b0});
        else
          chk($sformatf("lut_s%0d_sym%0d", s, k), {golden[s][k], 1'b0});
      end
    end

    // Unused symbol codes fall through to H in every state.
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        st  = 3'(s);
        sym = unused_codes[k];
        chk($sformatf("unused_s%0d_c%0d", s, k), {3'b111, unused_codes[k], 1'b0, 1'b0});
      end
    end

    // G / S0 leads to H; halted rises only at the first edge after release.
    @(negedge clk);
    st = 3'd6; sym = 3'b000;
    rst_n = 1'b1;
    chk("G_S0_before_edge", 8'b1110000_0);
    @(posedge clk);
    #2;
    chk("G_S0_halted", 8'b1110000_1);

    // A non-halting input does not clear the sticky flag.
    @(negedge clk);
    st = 3'd0; sym = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk($sformatf("sticky_A_%0d", i), 8'b0010011_1);
    end

    // Reset asserted mid-cycle clears halted at once, without a clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    chk("async_clear", 8'b0010011_0);

    // C with unused code 111 goes to H and sets halted.
    @(negedge clk);
    st = 3'd2; sym = 3'b111;
    rst_n = 1'b1;
    chk("C_111_comb", 8'b1111110_0);
    @(posedge clk);
    #2;
    chk("C_111_halted", 8'b1111110_1);

    // E / S4 loops on E without halting.
    @(negedge clk);
    rst_n = 1'b0;
    st = 3'd4; sym = 3'b100;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      chk($sformatf("E_S4_loop_%0d", i), 8'b1000000_0);
    end

    // Drain the scoreboard, with a bound on the wait.
    begin
      int guard;
      guard = 0;
      while (sb_exp.size() != 0 && guard < 100) begin
        #1;
        guard++;
      end
      if (sb_exp.size() != 0) begin
        n_bad++;
        $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_exp.size());
      end
    end
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
